// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer controller and its step timer.
package seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} seq_state_e;

  localparam int NOTE_W     = 12;
  localparam int MIN_TICKS  = 2;
  localparam int DEF_STEPS  = 16;
  localparam int DEF_STEP_W = 4;
  localparam int DEF_TICK_W = 24;
endpackage

// File: rtl/step_timer.sv
// Tick counter for one sequencer step: latches/clamps the step duration at step start
// and strobes step_end on the last tick. STEP_SWING_EN adds per-parity swing.
module step_timer
  import seq_pkg::*;
#(
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              Clock,
  input  logic              nStart,
  input  logic              run,
  input  logic              hold,
  input  logic              odd_next,
  input  logic [TICK_W-1:0] ticks_per_step,
`ifdef STEP_SWING_EN
  input  logic [TICK_W-1:0] swing_ticks,
`endif
  output logic [TICK_W-1:0] tick,
  output logic              step_end
);
  logic [TICK_W-1:0] tlat;
  logic [TICK_W-1:0] dur;

  always_comb begin
    dur = ticks_per_step;
`ifdef STEP_SWING_EN
    // Odd steps stretch (saturating at all-ones), even steps shrink (saturating at 0).
    if (odd_next) begin
      if ((TICK_W+1)'(ticks_per_step) + (TICK_W+1)'(swing_ticks) > (TICK_W+1)'({TICK_W{1'b1}}))
        dur = '1;
      else
        dur = ticks_per_step + swing_ticks;
    end else begin
      dur = (ticks_per_step > swing_ticks) ? ticks_per_step - swing_ticks : '0;
    end
`else
    if (odd_next) dur = ticks_per_step;
`endif
    if (dur < TICK_W'(MIN_TICKS)) dur = TICK_W'(MIN_TICKS);
  end

  assign step_end = run && (tick == tlat - TICK_W'(1));

  // Outside run/hold the timer sits primed for step 0 so the first step needs no extra cycle.
  always_ff @(posedge Clock or negedge nStart) begin
    if (!nStart) begin
      tick <= '0;
      tlat <= TICK_W'(MIN_TICKS);
    end else if (run) begin
      if (step_end) begin
        tick <= '0;
        tlat <= dur;
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end else if (!hold) begin
      tick <= '0;
      tlat <= dur;
    end
  end
endmodule

// File: rtl/step_sequencer_controller.sv
// Pattern step sequencer with play/pause/stop transport driving a 12-note Select bus.
// Optional STEP_SWING_EN adds a SwingTicks input for even/odd step swing.
module step_sequencer_controller
  import seq_pkg::*;
#(
  parameter int STEPS  = DEF_STEPS,
  parameter int STEP_W = DEF_STEP_W,
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              Clock,
  input  logic              nStart,
  input  logic              Play,
  input  logic              Pause,
  input  logic              Stop,
  input  logic [TICK_W-1:0] TicksPerStep,
  input  logic [TICK_W-1:0] GateTicks,
`ifdef STEP_SWING_EN
  input  logic [TICK_W-1:0] SwingTicks,
`endif
  input  logic [STEP_W-1:0] LoopLen,
  input  logic              WrEn,
  input  logic [STEP_W-1:0] WrAddr,
  input  logic [NOTE_W-1:0] WrData,
  output logic [NOTE_W-1:0] Select,
  output logic [STEP_W-1:0] Step,
  output logic              StepPulse,
  output logic              Running
);
  seq_state_e        state;
  logic [NOTE_W-1:0] pattern [STEPS];
  logic [TICK_W-1:0] tick;
  logic              step_end, run, hold, odd_next;
  logic [STEP_W-1:0] nxt;
  logic [TICK_W:0]   tick_inc, gate_ext;

  always_comb begin
    run      = (state == ST_RUN) && !Stop && !Pause;
    hold     = !Stop && ((state == ST_PAUSE) || (state == ST_RUN && Pause));
    nxt      = (Step >= LoopLen) ? '0 : Step + STEP_W'(1);
    odd_next = (state == ST_RUN) && nxt[0];
    tick_inc = (TICK_W+1)'(tick) + (TICK_W+1)'(1);
    gate_ext = (TICK_W+1)'(GateTicks);
  end

  // Same-edge writes are forwarded so a write to the sounding step appears on the next cycle.
  function automatic logic [NOTE_W-1:0] pat_at(input logic [STEP_W-1:0] idx);
    return (WrEn && WrAddr == idx) ? WrData : pattern[idx];
  endfunction

  step_timer #(.TICK_W(TICK_W)) u_timer (
    .Clock          (Clock),
    .nStart         (nStart),
    .run            (run),
    .hold           (hold),
    .odd_next       (odd_next),
    .ticks_per_step (TicksPerStep),
`ifdef STEP_SWING_EN
    .swing_ticks    (SwingTicks),
`endif
    .tick           (tick),
    .step_end       (step_end)
  );

  always_ff @(posedge Clock or negedge nStart) begin
    if (!nStart) begin
      for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
    end else if (WrEn) begin
      pattern[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clock or negedge nStart) begin
    if (!nStart) begin
      state     <= ST_IDLE;
      Select    <= '0;
      Step      <= '0;
      StepPulse <= 1'b0;
      Running   <= 1'b0;
    end else begin
      StepPulse <= 1'b0;
      unique case (state)
        ST_IDLE: if (Play && !Stop) begin
          state     <= ST_RUN;
          Running   <= 1'b1;
          Step      <= '0;
          StepPulse <= 1'b1;
          Select    <= (GateTicks != '0) ? pat_at('0) : '0;
        end
        ST_RUN: begin
          if (Stop) begin
            state   <= ST_IDLE;
            Select  <= '0;
            Step    <= '0;
            Running <= 1'b0;
          end else if (Pause) begin
            state   <= ST_PAUSE;
            Select  <= '0;
            Running <= 1'b0;
          end else if (step_end) begin
            Step      <= nxt;
            StepPulse <= 1'b1;
            Select    <= (GateTicks != '0) ? pat_at(nxt) : '0;
          end else begin
            Select <= (tick_inc < gate_ext) ? pat_at(Step) : '0;
          end
        end
        ST_PAUSE: begin
          if (Stop) begin
            state  <= ST_IDLE;
            Select <= '0;
            Step   <= '0;
          end else if (Play) begin
            // Resume replays the frozen tick without a new StepPulse.
            state   <= ST_RUN;
            Running <= 1'b1;
            Select  <= (tick < GateTicks) ? pat_at(Step) : '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/step_sequencer_controller.md
Name: step_sequencer_controller

Overview:
- Sequences the 12-note polyphonic tone generator bank.
- Holds a pattern of per-step 12-bit note masks and steps through them at a programmable tempo.
- Drives the generator's 12-bit note Select bus with a gated note mask each step.
- Sits between the front-panel/edit logic and the audio generator. Provides play/pause/stop transport and a step-position output for LEDs/display.

Parameters:
- STEPS, 16, number of pattern steps (power of two).
- STEP_W, 4, width of step index, log2(STEPS).
- TICK_W, 24, width of tempo and gate tick counters, in Clock cycles.

Ports:
- Clock  in  1  system clock.
- nStart  in  1  asynchronous active-low reset; clears all state, pattern and outputs.
- Play  in  1  single-cycle pulse; start from IDLE or resume from PAUSE.
- Pause  in  1  single-cycle pulse; RUN to PAUSE.
- Stop  in  1  single-cycle pulse; any state to IDLE.
- TicksPerStep  in  TICK_W  step duration in Clock cycles.
- GateTicks  in  TICK_W  cycles per step during which the note mask is sounded.
- LoopLen  in  STEP_W  index of the last step in the loop (0..STEPS-1).
- WrEn  in  1  pattern write strobe.
- WrAddr  in  STEP_W  pattern step to write.
- WrData  in  12  note mask; bit0 = C ... bit11 = B.
- Select  out  12  gated note mask to the generator bank.
- Step  out  STEP_W  current step index.
- StepPulse  out  1  high for the first cycle of every step.
- Running  out  1  high in RUN state.

Behaviour:
- Reset (nStart low, asynchronous):
  - State=IDLE.
  - Select=0, Step=0, StepPulse=0, Running=0.
  - Tick counter=0; all pattern entries=0.
- States are IDLE, RUN and PAUSE. Transport priority when pulses coincide: Stop > Pause > Play.
- IDLE:
  - Outputs held at their reset values (pattern retained).
  - Play moves to RUN.
  - The first cycle of step 0 appears in the cycle after the edge that samples Play: Step=0, StepPulse=1, Running=1.
- RUN, step timing:
  - Tick counts 0..Tlat-1, where Tlat is TicksPerStep latched at step start.
  - A latched value below 2 is clamped to 2.
  - When tick=Tlat-1, the next cycle begins a new step: tick=0, StepPulse=1.
  - Step becomes 0 if Step>=LoopLen; otherwise Step+1.
  - LoopLen is sampled only at step boundaries, so shrinking it below the current Step wraps to 0 at the next boundary.
- RUN, Select:
  - Select=pattern[Step] while tick<GateTicks; 0 otherwise.
  - GateTicks=0 gives silence; GateTicks>=Tlat gives legato (no gap).
  - Step, StepPulse and Select are registered and mutually aligned: all three change in the same cycle.
- RUN, transport:
  - Pause moves to PAUSE.
  - Stop moves to IDLE; outputs return to their reset values on the next cycle.
- PAUSE:
  - Tick and Step frozen; Select=0; Running=0; StepPulse=0.
  - Play resumes at the frozen tick with no new StepPulse; Select restores if tick<GateTicks.
  - Stop moves to IDLE.
- Pattern writes:
  - WrEn writes pattern[WrAddr]=WrData at the clock edge, in any state.
  - A write to the current step during its gate shows on Select one cycle later.
  - A write and a step boundary may coincide; the write always lands.
- Play while already in RUN is ignored. Pause in IDLE or PAUSE is ignored.

Optional Feature:
- Macro: STEP_SWING_EN.
- When defined:
  - Extra input SwingTicks (TICK_W) is added.
  - Even steps last TicksPerStep-SwingTicks cycles and odd steps last TicksPerStep+SwingTicks cycles.
  - The subtraction saturates; both durations are clamped to a minimum of 2.
  - The pair period is unchanged unless clamping occurs.
- When undefined: the port is absent and every step lasts the clamped TicksPerStep.

Decomposition:
- Package seq_pkg:
  - State enum (IDLE, RUN, PAUSE).
  - NOTE_W=12 and MIN_TICKS=2.
  - Default STEPS/STEP_W/TICK_W constants.
- One sub-module, step_timer:
  - Owns the tick counter, TicksPerStep latching/clamping and swing duration.
  - Emits a step_end strobe; inputs are run and hold.

Test Plan:
- Reset, write pattern[0]=0x001, [1]=0x090, LoopLen=1, TicksPerStep=4, GateTicks=2, Play -> StepPulse every 4 cycles. Select sequence is 0x001,0x001,0,0,0x090,0x090,0,0, repeating. Step toggles 0/1.
- Same setup, Pause at tick 1 of step 1, wait 10 cycles, Play -> Select=0 during pause. On resume, Select=0x090 for 1 cycle then 0, with no StepPulse until the boundary.
- TicksPerStep=0 -> steps last 2 cycles. GateTicks=0 -> Select stays 0 while Step advances.
- Play, Pause and Stop asserted in the same cycle from RUN -> IDLE next cycle: Select=0, Step=0, Running=0.
- While in step 3 with LoopLen=7, set LoopLen=2 -> the next boundary goes to Step=0. A write of 0xFFF to the current step mid-gate shows on Select one cycle later.
- STEP_SWING_EN, TicksPerStep=6, SwingTicks=2 -> even steps 4 cycles, odd steps 8 cycles. With SwingTicks=6, even steps clamp to 2 cycles.
